booth_mac_ctrl: RTL and testbench

Sequencing and accumulation stage wrapped around the `Booth` serial multiplier. Accepts signed operand pairs on a valid/ready input, issues each pair to the multiplier with a one-cycle `start` pulse, and waits for `busy` to fall. Adds each sign-extended `2N`-bit product into a guarded accumulator, then presents the dot-product result on a valid/ready output when the term flagged `last` completes. It is both the multiplier's upstream feeder and its downstream consumer.

---
 rtl/booth_mac_ctrl.sv | 172 +++++++++++++++++
 tb/tb_booth_mac_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mac_ctrl.sv
// Feeder/accumulator around a serial Booth multiplier: issues operand pairs,
// sums sign-extended products into a guarded accumulator, emits dot products.
module booth_mac_ctrl #(
  parameter int N = 8,
  parameter int G = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_last,
  output logic [N-1:0]     mul_op1,
  output logic [N-1:0]     mul_op2,
  output logic             mul_start,
  input  logic             mul_busy,
  input  logic [2*N-1:0]   mul_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N+G-1:0] out_acc,
  output logic [7:0]       out_terms,
  output logic             out_ovf
);

  localparam int ACC_W = 2*N + G;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N-1:0]       r_op1;
  logic [N-1:0]       r_op2;
  logic               r_last;
  logic [ACC_W-1:0]   r_acc;
  logic [7:0]         r_terms;
  logic               r_ovf;
  logic               r_in_ready;
  logic               r_mul_start;
  logic               r_out_valid;

  logic               w_accept;
  logic               w_acc_en;
  logic               w_clear;
  logic [ACC_W-1:0]   w_prod_ext;
  logic [ACC_W-1:0]   w_sum;
  logic               w_add_ovf;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return 8'hFF;
    end else begin
      return v + 8'd1;
    end
  endfunction

  // Overflow: equal-signed addends yielding a result of the other sign.
  always_comb begin
    w_prod_ext = {{G{mul_o[2*N-1]}}, mul_o};
    w_sum      = r_acc + w_prod_ext;
    w_add_ovf  = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                 (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
  end

  // Next-state decode and single-cycle action strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_acc_en    = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!mul_busy) begin
          w_acc_en    = 1'b1;
          w_state_nxt = r_last ? S_OUT : S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          w_clear     = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_OUT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; handshake outputs are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_mul_start <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_mul_start <= (w_state_nxt == S_START);
      r_out_valid <= (w_state_nxt == S_OUT);
    end
  end

  // Operand capture; held through START and WAIT for the multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op1  <= {N{1'b0}};
      r_op2  <= {N{1'b0}};
      r_last <= 1'b0;
    end else if (w_accept) begin
      r_op1  <= in_a;
      r_op2  <= in_b;
      r_last <= in_last;
    end else begin
      r_op1  <= r_op1;
      r_op2  <= r_op2;
      r_last <= r_last;
    end
  end

  // Accumulator, term count and sticky overflow; cleared on result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= {ACC_W{1'b0}};
      r_terms <= 8'd0;
      r_ovf   <= 1'b0;
    end else if (w_clear) begin
      r_acc   <= {ACC_W{1'b0}};
      r_terms <= 8'd0;
      r_ovf   <= 1'b0;
    end else if (w_acc_en) begin
      r_acc   <= w_sum;
      r_terms <= sat_inc8(r_terms);
      r_ovf   <= r_ovf | w_add_ovf;
    end else begin
      r_acc   <= r_acc;
      r_terms <= r_terms;
      r_ovf   <= r_ovf;
    end
  end

  assign in_ready  = r_in_ready;
  assign mul_op1   = r_op1;
  assign mul_op2   = r_op2;
  assign mul_start = r_mul_start;
  assign out_valid = r_out_valid;
  assign out_acc   = r_acc;
  assign out_terms = r_terms;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_booth_mac_ctrl.sv
// Scoreboard bench for booth_mac_ctrl with a behavioural serial multiplier.
module tb_booth_mac_ctrl;

  localparam int N = 8;
  localparam int G = 4;
  localparam int ACC_W = 2*N + G;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic             in_last;
  logic [N-1:0]     mul_op1;
  logic [N-1:0]     mul_op2;
  logic             mul_start;
  logic             mul_busy;
  logic [2*N-1:0]   mul_o;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [7:0]       out_terms;
  logic             out_ovf;

  booth_mac_ctrl #(.N(N), .G(G)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_start(mul_start),
    .mul_busy(mul_busy), .mul_o(mul_o),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_terms(out_terms), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Serial multiplier stand-in: busy for N cycles after a start edge.
  int                   m_cnt = 0;
  logic signed [2*N-1:0] m_prod = '0;
  always @(posedge clk) begin
    if (mul_start) begin
      m_cnt  <= N;
      m_prod <= $signed(mul_op1) * $signed(mul_op2);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end
  assign mul_busy = (m_cnt != 0);
  assign mul_o    = m_prod;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [19:0] acc;
    logic [7:0]  terms;
    logic        ovf;
  } exp_t;
  exp_t exp_q[$];

  int m_acc = 0;
  int m_terms = 0;
  bit m_ovf = 1'b0;

  task automatic model_clear();
    m_acc = 0;
    m_terms = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_push(input int a, input int b, input bit last);
    int   s;
    exp_t e;
    s = m_acc + a * b;
    if (s > 524287) begin
      s = s - 1048576;
      m_ovf = 1'b1;
    end else if (s < -524288) begin
      s = s + 1048576;
      m_ovf = 1'b1;
    end
    m_acc = s;
    m_terms = (m_terms < 255) ? m_terms + 1 : 255;
    if (last) begin
      e.acc = s[19:0];
      e.terms = m_terms[7:0];
      e.ovf = m_ovf;
      exp_q.push_back(e);
      model_clear();
    end
  endtask

  // Start-pulse counting, out_valid rise timing and scoreboard pop.
  int   start_cnt = 0;
  logic prev_start = 1'b0;
  logic prev_ov = 1'b0;
  int   ov_rise_cyc = 0;
  int   n_out = 0;
  always @(negedge clk) begin
    exp_t e;
    if (mul_start) begin
      start_cnt++;
      chk_val("start_single_cycle", {31'd0, prev_start}, 32'd0);
    end
    prev_start = mul_start;
    if (out_valid && !prev_ov) ov_rise_cyc = cyc;
    prev_ov = out_valid;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk_val("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk_val("out_acc", {12'd0, out_acc}, {12'd0, e.acc});
        chk_val("out_terms", {24'd0, out_terms}, {24'd0, e.terms});
        chk_val("out_ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
      end
      n_out++;
    end
  end

  int accept_cyc = 0;

  task automatic send(input int a, input int b, input bit last, input bit hold);
    bit ok;
    model_push(a, b, last);
    in_a = a[7:0];
    in_b = b[7:0];
    in_last = last;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk_val("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_out(input int target);
    for (int k = 0; k < 300; k++) begin
      if (n_out >= target) break;
      @(posedge clk);
      #1;
    end
    chk_val("result_timeout", {31'd0, (n_out >= target)}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int acc_hold;
    int a_prev;
    int tgt;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk_val("rst_mul_start", {31'd0, mul_start}, 32'd0);
    chk_val("rst_out_acc", {12'd0, out_acc}, 32'd0);
    chk_val("rst_out_terms", {24'd0, out_terms}, 32'd0);
    chk_val("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    chk_val("rst_mul_op1", {24'd0, mul_op1}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single term: latency and one start pulse
    out_ready = 1'b1;
    s0 = start_cnt;
    send(3, 5, 1'b1, 1'b0);
    wait_out(1);
    chk_val("latency", ov_rise_cyc - accept_cyc, 32'd10);
    chk_val("start_count_single", start_cnt - s0, 32'd1);

    // Signed mix
    send(-128, -128, 1'b0, 1'b0);
    send(-7, 9, 1'b0, 1'b0);
    send(127, -1, 1'b1, 1'b0);
    wait_out(2);

    // Overflow, then a fresh sum
    for (int i = 0; i < 32; i++) send(-128, -128, (i == 31), 1'b0);
    wait_out(3);
    send(1, 1, 1'b1, 1'b0);
    wait_out(4);

    // Backpressure
    out_ready = 1'b0;
    send(-2, 3, 1'b1, 1'b0);
    for (int k = 0; k < 50; k++) begin
      if (out_valid) break;
      @(posedge clk);
      #1;
    end
    chk_val("bp_valid_seen", {31'd0, out_valid}, 32'd1);
    acc_hold = int'(out_acc);
    s0 = start_cnt;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk_val("bp_acc_stable", {12'd0, out_acc}, acc_hold);
      chk_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk_val("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    chk_val("bp_no_start", start_cnt - s0, 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk_val("bp_one_handshake", n_out, 32'd5);
    chk_val("bp_valid_drop", {31'd0, out_valid}, 32'd0);
    chk_val("bp_cleared_acc", {12'd0, out_acc}, 32'd0);
    out_ready = 1'b1;
    send(1, 1, 1'b1, 1'b0);
    wait_out(6);

    // Reset during WAIT discards the in-flight term
    send(5, 5, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_val("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk_val("mid_rst_mul_start", {31'd0, mul_start}, 32'd0);
    chk_val("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    exp_q.delete();
    model_clear();
    @(posedge clk);
    #1;
    send(2, 2, 1'b1, 1'b0);
    wait_out(7);

    // Streaming with in_valid held high
    send(1, 1, 1'b0, 1'b1);
    a_prev = accept_cyc;
    for (int i = 0; i < 3; i++) begin
      send(1, 1, (i == 2), (i != 2));
      chk_val("stream_spacing", accept_cyc - a_prev, 32'd11);
      a_prev = accept_cyc;
    end
    tgt = 8;
    wait_out(tgt);
    chk_val("scoreboard_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
